des_sbox_sequencer: RTL

Controller that sequences the eight registered DES S-box units (S1..S8) for one Feistel-round substitution. It latches a 48-bit key-mixed expansion block, issues one select pulse per S-box in order S1→S8, and captures each 4-bit result on that box's finish flag. It assembles the 32-bit substitution output for the P-permutation stage and includes a per-box watchdog. It sits between the E-expansion/key-XOR stage and the P-permutation in the round datapath; the S-box instances are external.

---
 rtl/des_sbox_pkg.sv | 28 ++
 rtl/des_sbox_bank.sv | 58 +++++
 rtl/des_sbox_sequencer.sv | 109 ++++++++++
 3 files changed

// File: rtl/des_sbox_pkg.sv
// Shared types and constants for the DES S-box substitution stage.
// Slice helpers map a zero-based box number to its block/result bits.
package des_sbox_pkg;

    localparam int SBOX_IN_W  = 6;
    localparam int SBOX_OUT_W = 4;
    localparam int NUM_SBOX   = 8;
    localparam int BLOCK_W    = 48;
    localparam int RESULT_W   = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE,
        ERR
    } state_t;

    // S1 is box 0 and occupies the most significant slice.
    function automatic int in_lsb(input int n);
        return BLOCK_W - SBOX_IN_W * (n + 1);
    endfunction

    function automatic int out_lsb(input int n);
        return RESULT_W - SBOX_OUT_W * (n + 1);
    endfunction

endpackage

// File: rtl/des_sbox_bank.sv
// Eight registered DES S-boxes S1..S8 with one-cycle select-to-finish latency.
// Each output register holds its value until that box is selected again.
module des_sbox_bank
    import des_sbox_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BLOCK_W-1:0]  sbox_in,
    input  logic [NUM_SBOX-1:0] sbox_sel,
    output logic [RESULT_W-1:0] sbox_out,
    output logic [NUM_SBOX-1:0] sbox_fin
);

    // Tables are written row-major, entry 0 in the top nibble.
    function automatic logic [255:0] sbox_table(input int n);
        unique case (n)
            0: return 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
            1: return 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
            2: return 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
            3: return 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
            4: return 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
            5: return 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
            6: return 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
            default: return 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
        endcase
    endfunction

    for (genvar n = 0; n < NUM_SBOX; n++) begin : g_box
        localparam logic [255:0] TAB = sbox_table(n);

        logic [SBOX_IN_W-1:0]  s;
        logic [5:0]            ent;
        logic [SBOX_OUT_W-1:0] val;
        logic [SBOX_OUT_W-1:0] out_q;
        logic                  fin_q;

        assign s   = sbox_in[in_lsb(n) +: SBOX_IN_W];
        // Outer bits pick the row, inner four the column.
        assign ent = {s[5], s[0], s[4:1]};
        assign val = TAB[{~ent, 2'b00} +: SBOX_OUT_W];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_q <= '0;
                fin_q <= 1'b0;
            end else begin
                fin_q <= sbox_sel[n];
                if (sbox_sel[n]) begin
                    out_q <= val;
                end
            end
        end

        assign sbox_out[out_lsb(n) +: SBOX_OUT_W] = out_q;
        assign sbox_fin[n] = fin_q;
    end

endmodule

// File: rtl/des_sbox_sequencer.sv
// Sequences the external S-box bank for one Feistel-round substitution,
// one select pulse per box, with a per-box finish watchdog.
module des_sbox_sequencer
    import des_sbox_pkg::*;
#(
    parameter int NUM_SBOX       = 8,
    parameter int TIMEOUT_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [BLOCK_W-1:0]  block_in,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [RESULT_W-1:0] result,
    output logic [BLOCK_W-1:0]  sbox_in,
    output logic [NUM_SBOX-1:0] sbox_sel,
    input  logic [RESULT_W-1:0] sbox_out,
    input  logic [NUM_SBOX-1:0] sbox_fin
);

    localparam int IDX_W = $clog2(NUM_SBOX);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SBOX - 1);
    localparam logic [NUM_SBOX-1:0] SEL_ONE = NUM_SBOX'(1);
    localparam logic [RESULT_W-1:0] NIB = RESULT_W'(4'hF);

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [3:0]          wdog;
    logic [4:0]          wdog_inc;
    logic                timeout;
    logic [RESULT_W-1:0] slot_mask;
    logic [RESULT_W-1:0] merged;

    assign wdog_inc  = {1'b0, wdog} + 5'd1;
    assign timeout   = wdog_inc >= 5'(TIMEOUT_CYCLES);
    assign slot_mask = NIB << out_lsb(int'(idx));
    assign merged    = (result & ~slot_mask) | (sbox_out & slot_mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            result   <= '0;
            sbox_in  <= '0;
            sbox_sel <= '0;
            idx      <= '0;
            wdog     <= '0;
        end else begin
            done     <= 1'b0;
            sbox_sel <= '0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        sbox_in  <= block_in;
                        result   <= '0;
                        err      <= 1'b0;
                        idx      <= '0;
                        wdog     <= '0;
                        busy     <= 1'b1;
                        sbox_sel <= SEL_ONE;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    wdog  <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (sbox_fin[idx]) begin
                        result <= merged;
                        if (idx == LAST) begin
                            state <= DONE;
                        end else begin
                            idx      <= idx + 1'b1;
                            sbox_sel <= SEL_ONE << (idx + 1'b1);
                            state    <= ISSUE;
                        end
                    end else begin
                        if (wdog != 4'hF) begin
                            wdog <= wdog_inc[3:0];
                        end
                        if (timeout) begin
                            state <= ERR;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                ERR: begin
                    // Keep the slices captured so far for diagnosis.
                    err   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
